// File: rtl/rtc_timekeeper.sv
// Wall-clock timekeeper: sec/min/hour/day driven by a 1 Hz tick, with a 4-phase
// host load handshake and a sticky time-of-day alarm.
module rtc_timekeeper #(
    parameter int unsigned DAY_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             run_en,
    input  logic             set_req,
    input  logic [5:0]       set_sec,
    input  logic [5:0]       set_min,
    input  logic [4:0]       set_hour,
    input  logic [DAY_W-1:0] set_day,
    output logic             set_ack,
    output logic             set_err,
    input  logic             alm_en,
    input  logic [5:0]       alm_sec,
    input  logic [5:0]       alm_min,
    input  logic [4:0]       alm_hour,
    input  logic             alm_clr,
    output logic             alm_irq,
    output logic [5:0]       sec,
    output logic [5:0]       min,
    output logic [4:0]       hour,
    output logic [DAY_W-1:0] day,
    output logic             sec_pulse
);

    typedef enum logic [1:0] {IDLE, LOAD, ACK} state_t;

    state_t state, state_next;

    logic             advance;
    logic             set_valid;
    logic             alarm_hit;
    logic [5:0]       sec_next;
    logic [5:0]       min_next;
    logic [4:0]       hour_next;
    logic [DAY_W-1:0] day_next;

    // Ticks landing in the LOAD cycle are deliberately dropped.
    assign advance   = tick && run_en && (state != LOAD);
    assign set_valid = (set_sec <= 6'd59) && (set_min <= 6'd59) && (set_hour <= 5'd23);

    always_comb begin
        sec_next  = sec;
        min_next  = min;
        hour_next = hour;
        day_next  = day;
        if (sec == 6'd59) begin
            sec_next = '0;
            if (min == 6'd59) begin
                min_next = '0;
                if (hour == 5'd23) begin
                    hour_next = '0;
                    day_next  = day + 1'b1;
                end else begin
                    hour_next = hour + 5'd1;
                end
            end else begin
                min_next = min + 6'd1;
            end
        end else begin
            sec_next = sec + 6'd1;
        end
    end

    // Next-state values are always in range, so out-of-range alarm settings never hit.
    assign alarm_hit = advance && alm_en && (sec_next == alm_sec) &&
                       (min_next == alm_min) && (hour_next == alm_hour);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (set_req) state_next = LOAD;
            LOAD:    state_next = ACK;
            ACK:     if (!set_req) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sec       <= '0;
            min       <= '0;
            hour      <= '0;
            day       <= '0;
            sec_pulse <= 1'b0;
            alm_irq   <= 1'b0;
            set_ack   <= 1'b0;
            set_err   <= 1'b0;
        end else begin
            sec_pulse <= advance;
            if (advance) begin
                sec  <= sec_next;
                min  <= min_next;
                hour <= hour_next;
                day  <= day_next;
            end else if (state == LOAD && set_valid) begin
                sec  <= set_sec;
                min  <= set_min;
                hour <= set_hour;
                day  <= set_day;
            end

            if (alarm_hit) begin
                alm_irq <= 1'b1;
            end else if (alm_clr) begin
                alm_irq <= 1'b0;
            end

            case (state)
                LOAD: begin
                    set_ack <= 1'b1;
                    set_err <= !set_valid;
                end
                ACK: begin
                    if (!set_req) begin
                        set_ack <= 1'b0;
                        set_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Scoreboard bench for rtc_timekeeper: a behavioural model pushes the expected
// output snapshot per cycle; it is popped and compared after the clock edge.
module tb_rtc_timekeeper;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick, run_en, set_req;
    logic [5:0]  set_sec, set_min;
    logic [4:0]  set_hour;
    logic [15:0] set_day;
    logic        set_ack, set_err;
    logic        alm_en;
    logic [5:0]  alm_sec, alm_min;
    logic [4:0]  alm_hour;
    logic        alm_clr, alm_irq;
    logic [5:0]  sec, min;
    logic [4:0]  hour;
    logic [15:0] day;
    logic        sec_pulse;

    rtc_timekeeper #(.DAY_W(16)) dut (
        .clk(clk), .rst(rst), .tick(tick), .run_en(run_en),
        .set_req(set_req), .set_sec(set_sec), .set_min(set_min),
        .set_hour(set_hour), .set_day(set_day),
        .set_ack(set_ack), .set_err(set_err),
        .alm_en(alm_en), .alm_sec(alm_sec), .alm_min(alm_min),
        .alm_hour(alm_hour), .alm_clr(alm_clr), .alm_irq(alm_irq),
        .sec(sec), .min(min), .hour(hour), .day(day), .sec_pulse(sec_pulse)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Model state
    int          m_sec, m_min, m_hour, m_st;
    logic [15:0] m_day;
    bit          m_ack, m_err, m_irq, m_pulse;

    typedef struct {
        string       tag;
        logic [36:0] v;
    } exp_t;
    exp_t sb[$];

    function automatic logic [36:0] model_vec();
        return {m_ack, m_err, m_irq, m_pulse, 5'(m_hour), 6'(m_min), 6'(m_sec), m_day};
    endfunction

    function automatic logic [36:0] dut_vec();
        return {set_ack, set_err, alm_irq, sec_pulse, hour, min, sec, day};
    endfunction

    task automatic model_reset();
        m_sec = 0; m_min = 0; m_hour = 0; m_day = '0; m_st = 0;
        m_ack = 0; m_err = 0; m_irq = 0; m_pulse = 0;
    endtask

    task automatic model_update();
        bit adv, hit;
        int tod;
        adv = tick && run_en && (m_st != 1);
        hit = 0;
        m_pulse = adv;
        if (adv) begin
            tod = m_hour * 3600 + m_min * 60 + m_sec + 1;
            if (tod == 86400) begin
                tod = 0;
                m_day = m_day + 16'd1;
            end
            m_hour = tod / 3600;
            m_min  = (tod / 60) % 60;
            m_sec  = tod % 60;
            hit = alm_en && (int'(alm_sec) == m_sec) && (int'(alm_min) == m_min) &&
                  (int'(alm_hour) == m_hour);
        end
        if (hit) m_irq = 1;
        else if (alm_clr) m_irq = 0;
        case (m_st)
            0: if (set_req) m_st = 1;
            1: begin
                if (set_sec < 60 && set_min < 60 && set_hour < 24) begin
                    m_sec = set_sec; m_min = set_min; m_hour = set_hour; m_day = set_day;
                    m_err = 0;
                end else begin
                    m_err = 1;
                end
                m_ack = 1;
                m_st  = 2;
            end
            default: if (!set_req) begin m_st = 0; m_ack = 0; m_err = 0; end
        endcase
    endtask

    task automatic step(input string tag);
        exp_t e;
        model_update();
        sb.push_back('{tag, model_vec()});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq(e.tag, 64'(dut_vec()), 64'(e.v));
    endtask

    task automatic do_load(input int s, input int m, input int h, input logic [15:0] d);
        set_sec = 6'(s); set_min = 6'(m); set_hour = 5'(h); set_day = d;
        set_req = 1'b1;
        step("load_req");
        step("load_ld");
        step("load_ack");
        set_req = 1'b0;
        step("load_rel");
    endtask

    // Asserts reset away from any clock edge and checks outputs clear without one.
    task automatic async_reset(input string tag);
        #3 rst = 1'b0;
        #1 check_eq(tag, 64'(dut_vec()), 64'd0);
        model_reset();
        set_req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; tick = 0; run_en = 1; set_req = 0;
        set_sec = 0; set_min = 0; set_hour = 0; set_day = 0;
        alm_en = 0; alm_sec = 0; alm_min = 0; alm_hour = 0; alm_clr = 0;
        model_reset();
        #12;
        check_eq("reset_state", 64'(dut_vec()), 64'd0);
        rst = 1'b1;

        // Rollover
        do_load(59, 59, 23, 16'd5);
        tick = 1; step("roll_tick");
        tick = 0; step("roll_pulse_low");
        do_load(59, 59, 23, 16'hFFFF);
        tick = 1; step("day_wrap");
        tick = 0; step("day_wrap_idle");

        // Handshake with extended ACK hold
        set_sec = 56; set_min = 34; set_hour = 12; set_day = 16'd7; set_req = 1;
        step("hs_req");
        step("hs_ack");
        step("hs_hold1");
        step("hs_hold2");
        set_req = 0; step("hs_rel");

        // Invalid loads
        do_load(60, 0, 0, 16'd99);
        do_load(0, 0, 24, 16'd99);
        do_load(0, 60, 0, 16'd99);

        // Tick collisions
        set_sec = 0; set_min = 0; set_hour = 10; set_day = 16'd1; set_req = 1;
        step("coll_req");
        tick = 1; step("coll_load_tick");
        tick = 0; step("coll_ack");
        tick = 1; step("coll_ack_tick");
        tick = 0; set_req = 0; step("coll_rel");

        // Alarm
        alm_sec = 0; alm_min = 1; alm_hour = 0; alm_en = 1;
        do_load(59, 0, 0, 16'd0);
        tick = 1; step("alm_hit");
        tick = 0; step("alm_sticky");
        do_load(59, 0, 0, 16'd0);
        tick = 1; alm_clr = 1; step("alm_clr_vs_hit");
        tick = 0; step("alm_clr_only");
        alm_clr = 0;
        run_en = 0;
        for (int i = 0; i < 3; i++) begin
            tick = 1; step("frozen_tick");
        end
        tick = 0; run_en = 1;
        do_load(59, 0, 0, 16'd0);
        alm_en = 0; tick = 1; step("alm_disabled");
        tick = 0; alm_en = 1;
        alm_sec = 60; alm_min = 0; alm_hour = 0;
        for (int i = 0; i < 2; i++) begin
            tick = 1; step("alm_out_of_range");
        end
        tick = 0;

        // Async reset mid-run and mid-handshake
        async_reset("reset_midrun");
        tick = 1; step("post_reset_tick");
        tick = 0;
        set_sec = 1; set_min = 2; set_hour = 3; set_day = 16'd4; set_req = 1;
        step("abort_req");
        step("abort_ack");
        async_reset("reset_in_ack");
        do_load(1, 2, 3, 16'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
